cascade_ctrl: RTL
=================

Name: cascade_ctrl

Overview:
- Clocked, parametrised cascade-bus controller for the PIC: master/slave arbitration of the interrupt-acknowledge (INTA) sequence.
- Master: drives the cascade ID of the acknowledged slave, or claims the vector itself.
- Slave: matches the cascade ID against its own and enables its vector drive.
- Supports 8080 (3-pulse) and 8086 (2-pulse) INTA sequences, a configurable ID width and IR count, and an inter-pulse timeout.

Parameters:
- CASC_W, 3, cascade ID width.
- NUM_IR, 8, interrupt inputs per device. Must satisfy NUM_IR <= 2**CASC_W.
- TIMEOUT, 64, max clk cycles between INTA pulses before abort. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sngl  in  1  1 = single device, cascade unused.
- sp  in  1  1 = master, 0 = slave.
- mode_8086  in  1  1 = 2-pulse sequence, 0 = 3-pulse sequence.
- slave_map  in  NUM_IR  master: bit i set means a slave sits on IR i (ICW3).
- slave_id  in  CASC_W  slave: own cascade ID (ICW3).
- intr_valid  in  1  priority resolver has a pending IR.
- intr_id  in  $clog2(NUM_IR)  resolved IR number.
- inta_n  in  1  INTA strobe, already synchronous to clk.
- casc_in  in  CASC_W  cascade lines as read back.
- casc_out  out  CASC_W  cascade drive value.
- casc_oe  out  1  cascade output enable.
- vec_en  out  1  this device drives the data bus in the current vector pulse.
- byte_sel  out  2  0 = CALL opcode, 1 = low vector / 8086 vector, 2 = high vector.
- seq_done  out  1  one-cycle pulse when the sequence completes.
- seq_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, latches cleared. Reset mid-sequence aborts immediately; casc_oe drops asynchronously.
- Edge detection: inta_q registers inta_n.
  - fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
  - All decisions are taken on the cycle after the edge is visible.
- FSM states: IDLE, PULSE, GAP. Counter pcnt (2 bits) counts pulses seen; last = mode_8086 ? 2 : 3.
- IDLE -> PULSE on fall. On that transition, latch for the whole sequence:
  - id_l = intr_valid ? intr_id : NUM_IR-1 (spurious request maps to the lowest IR).
  - role flags: casc_mode = ~sngl; is_master = sp; mode_l = mode_8086.
  - Config inputs changing mid-sequence have no effect.
- Master, cascade mode:
  - On the first fall, if slave_map[id_l]: casc_out = id_l, casc_oe = 1 from the next cycle, held until the rise of the last pulse.
  - Otherwise: casc_out = 0, casc_oe = 0, and the master supplies the vector (owns = 1).
- Slave, cascade mode: on the first fall, sample casc_in one cycle later; owns = (casc_in == slave_id). casc_oe is always 0.
- sngl = 1: owns = 1, casc_oe = 0 for the whole sequence.
- vec_en = owns while in PULSE; 0 in GAP and IDLE.
  - Exception: in 3-pulse mode the master drives the CALL opcode on pulse 1 regardless of owns.
- byte_sel:
  - 3-pulse mode: 0, 1, 2 on pulses 1, 2, 3.
  - 2-pulse mode: byte_sel = 1 on pulse 2; vec_en = 0 on pulse 1 for all devices (8086 freeze pulse).
- PULSE -> GAP on rise.
  - If pcnt == last: go to IDLE instead, casc_oe = 0 the same cycle, seq_done pulses.
  - Otherwise increment pcnt.
- GAP -> PULSE on fall.
- Timeout: a GAP-only cycle counter of width $clog2(TIMEOUT+1) is cleared on entry to GAP. Reaching TIMEOUT forces IDLE, drops casc_oe and pulses seq_err; seq_done is not asserted.
- Simultaneous fall and timeout expiry: the fall wins.
- inta_n low at reset release: not treated as a fall. A rise must be seen before IDLE accepts a new fall.
- casc_oe and casc_out are registered; casc_out is 0 whenever casc_oe = 0.

Decomposition:
- Package pic_pkg:
  - typedef cascade_state_e {IDLE, PULSE, GAP}.
  - localparams BYTE_CALL = 0, BYTE_LO = 1, BYTE_HI = 2.
  - Pulse-count constants PULSES_8080 = 3, PULSES_8086 = 2.
- One sub-module, inta_edge_det: the registered edge detector plus the "rise seen since reset" qualifier, producing fall and rise.

Test Plan:
- Master 8080, slave_map = 8'h10, intr_id = 4, three INTA pulses -> casc_oe = 1 and casc_out = 3'd4 from pulse 1 to the last rise; vec_en = 1 only on pulse 1 (byte_sel = 0); seq_done on the final rise.
- Master 8086, slave_map = 0, intr_id = 2, two pulses -> casc_oe stays 0; vec_en = 0 on pulse 1; vec_en = 1 with byte_sel = 1 on pulse 2.
- Slave, slave_id = 5, casc_in = 5 vs casc_in = 6, 8080 sequence -> vec_en on pulses 2 and 3 only when matched, byte_sel 1 then 2; never vec_en when unmatched.
- sngl = 1, intr_valid = 0, 8086 -> id_l = 7; vec_en = 1 on pulse 2; casc_oe = 0 throughout.
- TIMEOUT = 64, master 8080: stall inta_n high for 64 cycles after pulse 1 -> seq_err pulse, casc_oe = 0, IDLE; the next fall starts a fresh pulse 1.
- Assert rst_n low during pulse 2 with casc_oe = 1 -> casc_oe = 0 immediately; after release with inta_n held low, no sequence starts until a rise then a fall.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC cascade-bus controller.
// Holds the cascade FSM state encoding, the byte_sel codes placed on the
// data bus during INTA pulses, and the number of INTA pulses per bus mode.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } cascade_state_e;

    // Byte driven on the data bus during a vector pulse
    localparam logic [1:0] BYTE_CALL = 2'd0;
    localparam logic [1:0] BYTE_LO   = 2'd1;
    localparam logic [1:0] BYTE_HI   = 2'd2;

    // INTA pulses per acknowledge sequence
    localparam logic [1:0] PULSES_8080 = 2'd3;
    localparam logic [1:0] PULSES_8086 = 2'd2;

endpackage

// File: rtl/cascade_ctrl_if.sv
// Cascade/INTA bus bundle between the interrupt logic and the controller.
// Signals:
//   intr_valid, intr_id : pending, resolved IR from the priority resolver
//   inta_n              : INTA strobe (already synchronous to clk)
//   casc_in             : cascade lines as read back
//   casc_out, casc_oe   : cascade drive value and output enable
//   vec_en, byte_sel    : vector drive enable and which byte to drive
//   seq_done, seq_err   : completion / timeout-abort pulses
// Modports: master drives the request side, slave is the controller view.
interface cascade_ctrl_if #(
    parameter int CASC_W = 3,
    parameter int NUM_IR = 8
);
    localparam int IDW = (NUM_IR > 1) ? $clog2(NUM_IR) : 1;

    logic              intr_valid;
    logic [IDW-1:0]    intr_id;
    logic              inta_n;
    logic [CASC_W-1:0] casc_in;
    logic [CASC_W-1:0] casc_out;
    logic              casc_oe;
    logic              vec_en;
    logic [1:0]        byte_sel;
    logic              seq_done;
    logic              seq_err;

    modport master (
        output intr_valid, intr_id, inta_n, casc_in,
        input  casc_out, casc_oe, vec_en, byte_sel, seq_done, seq_err
    );

    modport slave (
        input  intr_valid, intr_id, inta_n, casc_in,
        output casc_out, casc_oe, vec_en, byte_sel, seq_done, seq_err
    );
endinterface

// File: rtl/inta_edge_det.sv
// INTA edge detector.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inta_n     : synchronous INTA strobe
//   fall, rise : single-cycle edge indications
// fall is only reported once a rise has been seen since reset, so an INTA
// strobe already low when reset releases never starts a sequence.
module inta_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic fall,
    output logic rise
);
    logic inta_q;
    logic rise_seen;

    // inta_q resets low so a line held high at release reads as a rise,
    // arming the detector straight away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_q    <= 1'b0;
            rise_seen <= 1'b0;
        end else begin
            inta_q <= inta_n;
            if (rise) begin
                rise_seen <= 1'b1;
            end
        end
    end

    assign rise = ~inta_q & inta_n;
    assign fall = inta_q & ~inta_n & rise_seen;
endmodule

// File: rtl/cascade_ctrl.sv
// Cascade-bus controller for the PIC INTA sequence.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sngl       : single device, cascade unused
//   sp         : 1 = master, 0 = slave
//   mode_8086  : 2-pulse sequence when set, 3-pulse otherwise
//   slave_map  : master, bit i = slave present on IR i
//   slave_id   : slave, own cascade ID
//   bus        : cascade_ctrl_if.slave (INTA, cascade lines, vector control)
// The master either puts the acknowledged slave's ID on the cascade lines or
// supplies the vector itself; a slave claims the vector when the cascade ID
// matches its own. Configuration is latched on the first INTA fall.
module cascade_ctrl
    import pic_pkg::*;
#(
    parameter int CASC_W  = 3,
    parameter int NUM_IR  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sngl,
    input  logic              sp,
    input  logic              mode_8086,
    input  logic [NUM_IR-1:0] slave_map,
    input  logic [CASC_W-1:0] slave_id,
    cascade_ctrl_if.slave     bus
);
    localparam int IDW     = (NUM_IR > 1) ? $clog2(NUM_IR) : 1;
    localparam int TCNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    cascade_state_e    state;
    logic [1:0]        pcnt;
    logic [1:0]        last;
    logic [IDW-1:0]    id_l;
    logic [IDW-1:0]    next_id;
    logic              casc_mode;
    logic              is_master;
    logic              mode_l;
    logic              owns;
    logic              samp_pend;
    logic [TCNT_W-1:0] tcnt;
    logic              fall;
    logic              rise;
    logic              casc_oe_r;

    inta_edge_det u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .inta_n (bus.inta_n),
        .fall   (fall),
        .rise   (rise)
    );

    // A spurious request (nothing pending) is acknowledged as the lowest IR.
    assign next_id = bus.intr_valid ? bus.intr_id : IDW'(NUM_IR - 1);
    assign last    = mode_l ? PULSES_8086 : PULSES_8080;

    assign bus.casc_oe  = casc_oe_r;
    assign bus.casc_out = casc_oe_r ? CASC_W'(id_l) : '0;

    // Sequencer. pcnt holds the current pulse number while in PULSE and the
    // number of the next expected pulse while in GAP. A cascade slave learns
    // whether it owns the vector one cycle after the first fall, once the
    // master's cascade drive has settled; its first pulse never carries a
    // vector, so the late decision is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pcnt         <= 2'd0;
            id_l         <= '0;
            casc_mode    <= 1'b0;
            is_master    <= 1'b0;
            mode_l       <= 1'b0;
            owns         <= 1'b0;
            samp_pend    <= 1'b0;
            tcnt         <= '0;
            casc_oe_r    <= 1'b0;
            bus.vec_en   <= 1'b0;
            bus.byte_sel <= BYTE_CALL;
            bus.seq_done <= 1'b0;
            bus.seq_err  <= 1'b0;
        end else begin
            bus.seq_done <= 1'b0;
            bus.seq_err  <= 1'b0;

            if (samp_pend) begin
                samp_pend <= 1'b0;
                if (casc_mode && !is_master) begin
                    owns <= (bus.casc_in == slave_id);
                end
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state        <= PULSE;
                        pcnt         <= 2'd1;
                        id_l         <= next_id;
                        casc_mode    <= ~sngl;
                        is_master    <= sp;
                        mode_l       <= mode_8086;
                        samp_pend    <= 1'b1;
                        bus.byte_sel <= BYTE_CALL;
                        // In 3-pulse mode the master (or lone device) always
                        // drives the CALL opcode; 8086 pulse 1 is a freeze.
                        bus.vec_en   <= ~mode_8086 & (sp | sngl);
                        if (sngl) begin
                            owns      <= 1'b1;
                            casc_oe_r <= 1'b0;
                        end else if (sp) begin
                            owns      <= ~slave_map[next_id];
                            casc_oe_r <= slave_map[next_id];
                        end else begin
                            owns      <= 1'b0;
                            casc_oe_r <= 1'b0;
                        end
                    end
                end

                PULSE: begin
                    if (rise) begin
                        bus.vec_en   <= 1'b0;
                        bus.byte_sel <= BYTE_CALL;
                        if (pcnt == last) begin
                            state        <= IDLE;
                            casc_oe_r    <= 1'b0;
                            bus.seq_done <= 1'b1;
                        end else begin
                            state <= GAP;
                            pcnt  <= pcnt + 2'd1;
                            tcnt  <= '0;
                        end
                    end
                end

                GAP: begin
                    // A fall arriving on the expiry cycle still wins.
                    if (fall) begin
                        state        <= PULSE;
                        bus.vec_en   <= owns;
                        bus.byte_sel <= pcnt - 2'd1;
                    end else if ((TIMEOUT != 0) && (tcnt == TCNT_W'(TIMEOUT))) begin
                        state       <= IDLE;
                        casc_oe_r   <= 1'b0;
                        bus.seq_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
